// File: rtl/ppu_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM encodings, $zero specifier,
// and the MIPS opcode/funct codes the ID decoder uses for MULT/DIV and HI/LO moves.
package ppu_ctrl_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  function automatic logic is_md_funct(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == OP_SPECIAL) &&
           (funct == FUNCT_MULT || funct == FUNCT_MULTU ||
            funct == FUNCT_DIV  || funct == FUNCT_DIVU);
  endfunction

  function automatic logic is_hilo_funct(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == OP_SPECIAL) &&
           (funct == FUNCT_MFHI || funct == FUNCT_MTHI ||
            funct == FUNCT_MFLO || funct == FUNCT_MTLO);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID/EX hazard-control bundle: decode and EX-stage inputs plus the
// pipeline-register enables and status produced by the hazard controller.
interface pipeline_hazard_ctrl_if #(parameter int REG_W = 5);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_md_start;
  logic             id_uses_hilo;
  logic             ex_load;
  logic             ex_regwrite;
  logic [REG_W-1:0] ex_wdest;
  logic             pc_le;
  logic             if_id_le;
  logic             id_ex_nop;
  logic             md_busy;
  logic [31:0]      stall_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_md_start, id_uses_hilo,
           ex_load, ex_regwrite, ex_wdest,
    input  pc_le, if_id_le, id_ex_nop, md_busy, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_md_start, id_uses_hilo,
           ex_load, ex_regwrite, ex_wdest,
    output pc_le, if_id_le, id_ex_nop, md_busy, stall_cnt
  );
endinterface

// File: rtl/md_occupancy_counter.sv
// Loadable down-counter tracking how many cycles the MULT/DIV unit stays
// occupied; flags the final busy cycle so the controller can return to RUN.
module md_occupancy_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] value,
  output logic       busy,
  output logic       last
);

  logic [3:0] md_cnt_q, md_cnt_d;

  // Saturates at zero so an idle counter never wraps.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (load) begin
      md_cnt_d = value;
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt_q <= 4'd0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign busy = (md_cnt_q != 4'd0);
  assign last = (md_cnt_q == 4'd1);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/bubble sequencer for load-use and MULT/DIV occupancy hazards.
// Optional HAZ_PERF_CNT_EN builds a 32-bit stalled-cycle counter.
module pipeline_hazard_ctrl
  import ppu_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 4,
  parameter int REG_W     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave hz
);

  md_state_e state_q, state_d;
  logic      ld_haz, md_haz, stall;
  logic      md_load, md_last, md_cnt_busy;
  logic      pc_le, if_id_le, id_ex_nop, md_busy;

  always_comb begin
    ld_haz = hz.ex_load && hz.ex_regwrite && (hz.ex_wdest != REG_W'(REG_ZERO)) &&
             ((hz.id_uses_rs && (hz.id_rs == hz.ex_wdest)) ||
              (hz.id_uses_rt && (hz.id_rt == hz.ex_wdest)));
    md_haz = (state_q == ST_MD_BUSY) && (hz.id_uses_hilo || hz.id_md_start);
    stall  = ld_haz || md_haz;
  end

  // A MULT/DIV held back by a stall is not accepted; it retries next cycle.
  always_comb begin
    state_d = state_q;
    md_load = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (hz.id_md_start && !stall && (MD_CYCLES > 1)) begin
          md_load = 1'b1;
          state_d = ST_MD_BUSY;
        end
      end
      ST_MD_BUSY: begin
        if (md_last) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  md_occupancy_counter u_md_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (md_load),
    .value (4'(MD_CYCLES - 1)),
    .busy  (md_cnt_busy),
    .last  (md_last)
  );

  // Reset forces the pipeline frozen with a bubble, independent of the clock.
  always_comb begin
    pc_le     = 1'b0;
    if_id_le  = 1'b0;
    id_ex_nop = 1'b1;
    md_busy   = 1'b0;
    if (reset) begin
      pc_le     = !stall;
      if_id_le  = !stall;
      id_ex_nop = stall;
      md_busy   = (state_q == ST_MD_BUSY) && md_cnt_busy;
    end
  end

  assign hz.pc_le     = pc_le;
  assign hz.if_id_le  = if_id_le;
  assign hz.id_ex_nop = id_ex_nop;
  assign hz.md_busy   = md_busy;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
`else
  assign hz.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl (MD_CYCLES=4),
// with hand-written reset sequences; tracks stall_cnt when HAZ_PERF_CNT_EN is set.
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic reset;

  pipeline_hazard_ctrl_if #(.REG_W(5)) hz ();

  pipeline_hazard_ctrl #(.MD_CYCLES(4), .REG_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       md_start;
    logic       hilo;
    logic       ex_load;
    logic       ex_rw;
    logic [4:0] wdest;
    logic       exp_stall;
    logic       exp_busy;
  } vec_t;

  vec_t        vecs[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] exp_cnt    = 32'd0;

  function automatic vec_t mk(input string name, input logic [4:0] rs, input logic [4:0] rt,
                              input logic use_rs, input logic use_rt, input logic md_start,
                              input logic hilo, input logic ex_load, input logic ex_rw,
                              input logic [4:0] wdest, input logic exp_stall, input logic exp_busy);
    vec_t v;
    v.name = name; v.rs = rs; v.rt = rt; v.use_rs = use_rs; v.use_rt = use_rt;
    v.md_start = md_start; v.hilo = hilo; v.ex_load = ex_load; v.ex_rw = ex_rw;
    v.wdest = wdest; v.exp_stall = exp_stall; v.exp_busy = exp_busy;
    return v;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    hz.id_rs        = v.rs;
    hz.id_rt        = v.rt;
    hz.id_uses_rs   = v.use_rs;
    hz.id_uses_rt   = v.use_rt;
    hz.id_md_start  = v.md_start;
    hz.id_uses_hilo = v.hilo;
    hz.ex_load      = v.ex_load;
    hz.ex_regwrite  = v.ex_rw;
    hz.ex_wdest     = v.wdest;
    #1;
  endtask

  task automatic check_output(input vec_t v);
    check_bit({v.name, ".pc_le"},     hz.pc_le,     !v.exp_stall);
    check_bit({v.name, ".if_id_le"},  hz.if_id_le,  !v.exp_stall);
    check_bit({v.name, ".id_ex_nop"}, hz.id_ex_nop, v.exp_stall);
    check_bit({v.name, ".md_busy"},   hz.md_busy,   v.exp_busy);
`ifdef HAZ_PERF_CNT_EN
    check_word({v.name, ".stall_cnt"}, hz.stall_cnt, exp_cnt);
`else
    check_word({v.name, ".stall_cnt"}, hz.stall_cnt, 32'd0);
`endif
    if (v.exp_stall) exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic run_vec(input vec_t v);
    apply_stimulus(v);
    check_output(v);
  endtask

  initial begin
    reset = 1'b0;
    hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rs = 1'b0; hz.id_uses_rt = 1'b0;
    hz.id_md_start = 1'b0; hz.id_uses_hilo = 1'b0; hz.ex_load = 1'b0;
    hz.ex_regwrite = 1'b0; hz.ex_wdest = '0;

    //   name         rs  rt  urs urt md  hl  ld  rw  wd  stall busy
    vecs.push_back(mk("idle0",     0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("lu_rs",     8,  0, 1, 0, 0, 0, 1, 1, 8, 1, 0));
    vecs.push_back(mk("lu_rs_rel", 8,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("lu_rt",     0,  8, 0, 1, 0, 0, 1, 1, 8, 1, 0));
    vecs.push_back(mk("lu_rt_rel", 0,  8, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("zero_dest", 0,  0, 1, 1, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk("no_use_rs", 8,  0, 0, 0, 0, 0, 1, 1, 8, 0, 0));
    vecs.push_back(mk("no_rw",     8,  0, 1, 0, 0, 0, 1, 0, 8, 0, 0));
    vecs.push_back(mk("rs_differ", 9,  0, 1, 0, 0, 0, 1, 1, 8, 0, 0));
    vecs.push_back(mk("mult_a",    0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("mult_b",    0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("mfhi_c",    0,  0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk("mfhi_d",    0,  0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk("mfhi_e",    0,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("m2_a",      0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("m2_b",      0,  0, 0, 0, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk("m2_c",      0,  0, 0, 0, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk("m2_d",      0,  0, 0, 0, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk("m2_e",      0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("m2_f",      0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("m2_g",      0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("m2_h",      0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("m2_i",      0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("both_a",    0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("both_b",    3,  0, 1, 0, 0, 1, 1, 1, 3, 1, 1));
    vecs.push_back(mk("both_c",    3,  0, 1, 0, 0, 1, 1, 1, 3, 1, 1));
    vecs.push_back(mk("both_d",    3,  0, 1, 0, 0, 1, 1, 1, 3, 1, 1));
    vecs.push_back(mk("lu_only_e", 3,  0, 1, 0, 0, 1, 1, 1, 3, 1, 0));
    vecs.push_back(mk("mfhi_f",    3,  0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("md_ldhaz",  0,  5, 0, 1, 1, 0, 1, 1, 5, 1, 0));
    vecs.push_back(mk("md_retry",  0,  5, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("retry_b1",  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("retry_b2",  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("retry_b3",  0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("retry_end", 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset state with a hazard-free ID stage.
    #12;
    check_bit("rst.pc_le",     hz.pc_le,     1'b0);
    check_bit("rst.if_id_le",  hz.if_id_le,  1'b0);
    check_bit("rst.id_ex_nop", hz.id_ex_nop, 1'b1);
    check_bit("rst.md_busy",   hz.md_busy,   1'b0);
    check_word("rst.stall_cnt", hz.stall_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset asserted while MD_BUSY with md_cnt=2.
    run_vec(mk("mr_mult", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    run_vec(mk("mr_cnt3", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    run_vec(mk("mr_cnt2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    #2;
    reset = 1'b0;
    #1;
    check_bit("mr.pc_le",     hz.pc_le,     1'b0);
    check_bit("mr.if_id_le",  hz.if_id_le,  1'b0);
    check_bit("mr.id_ex_nop", hz.id_ex_nop, 1'b1);
    check_bit("mr.md_busy",   hz.md_busy,   1'b0);
    check_word("mr.stall_cnt", hz.stall_cnt, 32'd0);
    exp_cnt = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    run_vec(mk("post_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    run_vec(mk("post_mfhi", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    run_vec(mk("post_mult", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    run_vec(mk("post_mfhi2", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
    run_vec(mk("post_lu",   7, 0, 1, 0, 0, 0, 1, 1, 7, 1, 1));
    run_vec(mk("post_end",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    run_vec(mk("post_run",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
